sha256_message_schedule: RTL

//  Consumes the 512-bit block assembled by the message collector and streams out the
//  SHA-256 message-schedule words W[0..ROUNDS-1], one word per accepted handshake, to
//  the compression-round engine. Holds a 16-word sliding window; computes W[t+16] on the fly.

---
 rtl/sha256_message_schedule.sv | 97 +++++++++
 1 files changed

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W[0..ROUNDS-1]
// over a valid/ready handshake from a 16-word sliding window.
module sha256_message_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w,
  output logic [5:0]   t,
  output logic         done
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_win [16];
  logic [5:0]  r_t;
  logic        r_done;
  logic        w_load;
  logic        w_fire;
  logic        w_last;
  logic [31:0] w_new;

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    f_s0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    f_s1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_last = (r_t == LAST);
  assign w_new  = f_s1(r_win[14]) + r_win[9]
                + f_s0(r_win[1]) + r_win[0];

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_fire = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = in_valid;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        w_fire = w_ready;
        if (w_ready && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fire && w_last;
      unique case (1'b1)
        w_load: begin
          for (int i = 0; i < 16; i++)
            r_win[i] <= block[511-32*i -: 32];
          r_t <= '0;
        end
        (w_fire && !w_last): begin
          for (int i = 0; i < 15; i++)
            r_win[i] <= r_win[i+1];
          r_win[15] <= w_new;
          r_t       <= r_t + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // ready is forced low for the whole time reset is held
  assign in_ready = (r_state == S_IDLE) && !reset;
  assign w_valid  = (r_state == S_RUN);
  assign w        = r_win[0];
  assign t        = r_t;
  assign done     = r_done;

endmodule
